counter_ctrl: RTL

- Command-side controller for the interval counter. It drives the 8-bit `state` command (RESET/RUN/HALT) and the 32-bit `inter` interval value, and it reads back the counter's `count` output.
- It turns one-cycle user pulses (`start`, `stop`, `clear`) into the command sequence.
- It auto-halts when `count` reaches a programmed target and raises `done`. It also keeps a snapshot of `count` at the last halt.
- Sits between the board/user control logic and the counter instance in the p0 top level.

---
 rtl/counter_ctrl_if.sv | 25 ++
 rtl/counter_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/counter_ctrl_if.sv
// Command/feedback bundle between the board control logic and counter_ctrl.
// The master side issues pulses and feeds back count; the slave side is the controller.
interface counter_ctrl_if;
    logic        start;
    logic        stop;
    logic        clear;
    logic [31:0] inter_in;
    logic [31:0] target_in;
    logic [31:0] count;
    logic [7:0]  state;
    logic [31:0] inter;
    logic        busy;
    logic        done;
    logic [31:0] count_snap;

    modport master (
        output start, stop, clear, inter_in, target_in, count,
        input  state, inter, busy, done, count_snap
    );

    modport slave (
        input  start, stop, clear, inter_in, target_in, count,
        output state, inter, busy, done, count_snap
    );
endinterface

// File: rtl/counter_ctrl.sv
// Command-side controller for the interval counter: turns start/stop/clear pulses
// into RESET/RUN/HALT commands and auto-halts on target. Optional macro: AUTO_RELOAD_EN.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_RESET | idle; counter held in reset; start latches inter/target
// S_RUN   | counter running; target hit or stop leaves this state
// S_HALT  | counter frozen; start resumes, clear returns to idle
module counter_ctrl #(
    parameter logic [7:0] ST_RESET = 8'd0,
    parameter logic [7:0] ST_RUN   = 8'd1,
    parameter logic [7:0] ST_HALT  = 8'd2
) (
    input  logic           clk,
    input  logic           rst,
    counter_ctrl_if.slave  ctrl
);

    typedef enum logic [7:0] {
        S_RESET = ST_RESET,
        S_RUN   = ST_RUN,
        S_HALT  = ST_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] inter_q, inter_d;
    logic [31:0] target_q, target_d;
    logic [31:0] snap_q, snap_d;
    logic        done_q, done_d;
    logic        busy_q;
    logic        reload_q, reload_d;
    logic        target_hit;

    assign target_hit = (target_q != 32'd0) && (ctrl.count >= target_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RESET;
            inter_q  <= 32'd0;
            target_q <= 32'd0;
            snap_q   <= 32'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            reload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            inter_q  <= inter_d;
            target_q <= target_d;
            snap_q   <= snap_d;
            done_q   <= done_d;
            busy_q   <= (state_d == S_RUN);
            reload_q <= reload_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        inter_d  = inter_q;
        target_d = target_q;
        snap_d   = snap_q;
        done_d   = 1'b0;
        reload_d = 1'b0;
        case (state_q)
            S_RESET: begin
                if (ctrl.clear || ctrl.stop) begin
                    state_d = S_RESET;
                end else if (reload_q) begin
                    // Periodic restart keeps the interval and target already latched.
                    state_d = S_RUN;
                end else if (ctrl.start) begin
                    state_d  = S_RUN;
                    inter_d  = ctrl.inter_in;
                    target_d = ctrl.target_in;
                end
            end
            S_RUN: begin
                if (ctrl.clear) begin
                    state_d = S_RESET;
                end else if (ctrl.stop) begin
                    state_d = S_HALT;
                    snap_d  = ctrl.count;
                end else if (target_hit) begin
                    done_d = 1'b1;
                    snap_d = ctrl.count;
`ifdef AUTO_RELOAD_EN
                    state_d  = S_RESET;
                    reload_d = 1'b1;
`else
                    state_d = S_HALT;
`endif
                end
            end
            S_HALT: begin
                if (ctrl.clear) begin
                    state_d = S_RESET;
                end else if (ctrl.start) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    assign ctrl.state      = state_q;
    assign ctrl.inter      = inter_q;
    assign ctrl.busy       = busy_q;
    assign ctrl.done       = done_q;
    assign ctrl.count_snap = snap_q;

endmodule
